// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with circular return-address stack and sticky overflow/underflow flags
module pc_stack_unit #(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              INC      = 1,
    parameter int              DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       branch_en,
    input  logic                       call_en,
    input  logic                       ret_en,
    input  logic [PC_W-1:0]            target,
    output logic [PC_W-1:0]            pc_out,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       stk_empty,
    output logic                       stk_full,
    output logic                       ovf,
    output logic                       unf
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;
    logic [PC_W-1:0] stack [DEPTH];
    logic [AW-1:0]   sp;
    logic [AW-1:0]   top_idx;
    logic [PC_W-1:0] seq_pc;
    logic            push;
    logic            pop;
    assign seq_pc    = pc_out + PC_W'(INC);
    assign top_idx   = sp - 1'b1;
    assign stk_empty = depth == '0;
    assign stk_full  = depth == DW'(DEPTH);
    assign push      = !reset && !stall && !ret_en && call_en;
    assign pop       = !reset && !stall && ret_en && !stk_empty;
    // a push when full lands on the oldest slot, so the pointer simply wraps
    always_ff @(posedge clk) begin
        if (push)
            stack[sp] <= seq_pc;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out <= RESET_PC;
            sp     <= '0;
            depth  <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else if (!stall) begin
            pc_out <= ret_en ? (stk_empty ? seq_pc : stack[top_idx])
                    : (call_en || branch_en) ? target : seq_pc;
            sp     <= push ? sp + 1'b1 : pop ? top_idx : sp;
            depth  <= (push && !stk_full) ? depth + 1'b1 : pop ? depth - 1'b1 : depth;
            ovf    <= ovf | (push && stk_full);
            unf    <= unf | (ret_en && stk_empty);
        end
    end
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: queue-based reference model checked every cycle plus directed literal checks
module tb_pc_stack_unit;
    logic       clk = 0;
    logic       reset = 1;
    logic       stall = 0;
    logic       branch_en = 0;
    logic       call_en = 0;
    logic       ret_en = 0;
    logic [9:0] target = '0;
    logic [9:0] pc_out;
    logic [2:0] depth;
    logic       stk_empty, stk_full, ovf, unf;
    int compared = 0;
    int mismatched = 0;
    bit started = 0;
    logic [9:0] m_pc = '0;
    logic [9:0] m_q[$];
    bit m_ovf = 0;
    bit m_unf = 0;

    pc_stack_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_en(branch_en),
        .call_en(call_en), .ret_en(ret_en), .target(target), .pc_out(pc_out),
        .depth(depth), .stk_empty(stk_empty), .stk_full(stk_full), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: a plain queue, newest at the back, oldest dropped on overflow
    always @(posedge clk) begin
        if (reset) begin
            m_pc = '0;
            m_q.delete();
            m_ovf = 0;
            m_unf = 0;
            started = 1;
        end else if (!stall) begin
            if (ret_en) begin
                if (m_q.size() == 0) begin
                    m_pc = m_pc + 10'd1;
                    m_unf = 1;
                end else m_pc = m_q.pop_back();
            end else if (call_en) begin
                m_q.push_back(m_pc + 10'd1);
                if (m_q.size() > 4) begin
                    void'(m_q.pop_front());
                    m_ovf = 1;
                end
                m_pc = target;
            end else if (branch_en) m_pc = target;
            else m_pc = m_pc + 10'd1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_pc", pc_out, m_pc);
            chk("model_depth", depth, m_q.size());
            chk("model_empty", stk_empty, m_q.size() == 0);
            chk("model_full", stk_full, m_q.size() == 4);
            chk("model_ovf", ovf, m_ovf);
            chk("model_unf", unf, m_unf);
        end
    end

    task automatic step(input logic s, input logic c, input logic r, input logic b, input logic [9:0] t);
        stall = s; call_en = c; ret_en = r; branch_en = b; target = t;
        @(negedge clk);
    endtask

    initial begin
        step(0, 0, 0, 0, 0);
        reset = 0;
        chk("rst_pc", pc_out, 0);
        chk("rst_depth", depth, 0);
        chk("rst_empty", stk_empty, 1);
        chk("rst_full", stk_full, 0);
        chk("rst_flags", {ovf, unf}, 0);
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 0, 0, 0);
            chk("free_pc", pc_out, i);
        end
        step(0, 1, 0, 0, 10'h100);
        chk("call_pc", pc_out, 10'h100);
        chk("call_depth", depth, 1);
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 0, 0, 0);
            chk("sub_pc", pc_out, 10'h100 + i);
        end
        step(0, 0, 1, 0, 0);
        chk("ret_pc", pc_out, 6);
        chk("ret_depth", depth, 0);
        step(0, 0, 0, 1, 10'h3FF);
        chk("br_pc", pc_out, 10'h3FF);
        step(0, 0, 0, 0, 0);
        chk("wrap_pc", pc_out, 0);
        chk("wrap_flags", {ovf, unf}, 0);
        step(0, 0, 0, 1, 10);
        for (int i = 2; i <= 6; i++) step(0, 1, 0, 0, 10'(i * 10));
        chk("ovf_flag", ovf, 1);
        chk("ovf_full", stk_full, 1);
        chk("ovf_depth", depth, 4);
        chk("ovf_pc", pc_out, 60);
        step(0, 0, 1, 0, 0); chk("pop1", pc_out, 51);
        step(0, 0, 1, 0, 0); chk("pop2", pc_out, 41);
        step(0, 0, 1, 0, 0); chk("pop3", pc_out, 31);
        step(0, 0, 1, 0, 0); chk("pop4", pc_out, 21);
        chk("pop_unf_before", unf, 0);
        step(0, 0, 1, 0, 0);
        chk("unf_pc", pc_out, 22);
        chk("unf_flag", unf, 1);
        chk("unf_depth", depth, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 10'h200);
            chk("stall_pc", pc_out, 22);
            chk("stall_depth", depth, 0);
        end
        step(0, 1, 0, 0, 10'h200);
        chk("release_pc", pc_out, 10'h200);
        chk("release_depth", depth, 1);
        step(0, 1, 0, 0, 10'h300);
        chk("d2_depth", depth, 2);
        step(0, 1, 1, 1, 10'h050);
        chk("prio_pc", pc_out, 10'h201);
        chk("prio_depth", depth, 1);
        step(1, 0, 1, 0, 0);
        chk("stall_ret_pc", pc_out, 10'h201);
        step(0, 0, 0, 1, 10'h0AA);
        chk("br_only_pc", pc_out, 10'h0AA);
        chk("br_depth", depth, 1);
        step(0, 1, 0, 0, 10'h123);
        reset = 1;
        step(0, 1, 0, 0, 10'h155);
        reset = 0;
        chk("rst_call_pc", pc_out, 0);
        chk("rst_call_depth", depth, 0);
        chk("rst_call_flags", {ovf, unf}, 0);
        step(0, 0, 0, 0, 0);
        chk("post_rst_pc", pc_out, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
